// File: rtl/mem_copy_if.sv
// Control and memory-bus signals of the word copy engine.
//   master : engine side. Takes the copy request and read data, and drives status and the
//            memory address, write enable and write data.
//   slave  : environment side. Drives the request and RD, and observes everything else.
// Signals: start, src_addr, dst_addr, len (request); busy, done, err, words_done (status);
//          A, WE, WD, RD (single-port memory with combinational read).
interface mem_copy_if #(
   parameter int unsigned BUS_WIDTH = 32,
   parameter int unsigned LEN_WIDTH = 16
);
   logic                 start;
   logic [BUS_WIDTH-1:0] src_addr;
   logic [BUS_WIDTH-1:0] dst_addr;
   logic [LEN_WIDTH-1:0] len;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [LEN_WIDTH-1:0] words_done;
   logic [BUS_WIDTH-1:0] A;
   logic                 WE;
   logic [BUS_WIDTH-1:0] WD;
   logic [BUS_WIDTH-1:0] RD;

   modport master (
      input  start, src_addr, dst_addr, len, RD,
      output busy, done, err, words_done, A, WE, WD
   );

   modport slave (
      output start, src_addr, dst_addr, len, RD,
      input  busy, done, err, words_done, A, WE, WD
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine. Each word costs one READ cycle, which fetches it from
// src_ptr, and one WRITE cycle, which stores it to dst_ptr. The copy runs in ascending
// address order.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_copy_if.master. Carries the request (start/src_addr/dst_addr/len), the status
//           (busy/done/err/words_done) and the memory port (A/WE/WD/RD).
module mem_copy_engine #(
   parameter int unsigned BUS_WIDTH = 32,
   parameter int unsigned LEN_WIDTH = 16,
   parameter int unsigned ADDR_INC  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_copy_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   localparam logic [BUS_WIDTH-1:0] AddrInc = BUS_WIDTH'(ADDR_INC);
   localparam logic [LEN_WIDTH-1:0] LenOne  = LEN_WIDTH'(1);

   state_e               state_q, state_d;
   logic [BUS_WIDTH-1:0] src_ptr_q, src_ptr_d;
   logic [BUS_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0] words_done_q, words_done_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic [BUS_WIDTH-1:0] a_q, a_d;
   logic                 err_q, err_d;
   logic [BUS_WIDTH-1:0] a_out;
   logic                 misaligned;

   assign misaligned = ((bus.src_addr % AddrInc) != '0) || ((bus.dst_addr % AddrInc) != '0);

   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      remaining_d  = remaining_q;
      words_done_d = words_done_q;
      data_d       = data_q;
      err_d        = err_q;
      // A holds the last driven address in IDLE and DONE.
      a_out        = a_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               src_ptr_d    = bus.src_addr;
               dst_ptr_d    = bus.dst_addr;
               remaining_d  = bus.len;
               words_done_d = '0;
               err_d        = 1'b0;
               // A zero length wins over misalignment, so it ends without err.
               if (bus.len == '0) begin
                  state_d = StDone;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            a_out     = src_ptr_q;
            data_d    = bus.RD;
            src_ptr_d = src_ptr_q + AddrInc;
            state_d   = StWrite;
         end
         StWrite: begin
            a_out        = dst_ptr_q;
            dst_ptr_d    = dst_ptr_q + AddrInc;
            remaining_d  = remaining_q - LenOne;
            words_done_d = words_done_q + LenOne;
            state_d      = (remaining_q == LenOne) ? StDone : StRead;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      a_d = a_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         src_ptr_q    <= '0;
         dst_ptr_q    <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
         data_q       <= '0;
         a_q          <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         remaining_q  <= remaining_d;
         words_done_q <= words_done_d;
         data_q       <= data_d;
         a_q          <= a_d;
         err_q        <= err_d;
      end
   end

   // All outputs decode from registered state, so an asynchronous reset clears WE at once.
   assign bus.A          = a_out;
   assign bus.WE         = (state_q == StWrite);
   assign bus.WD         = data_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.done       = (state_q == StDone);
   assign bus.err        = err_q;
   assign bus.words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a 1024-word memory model with combinational reads and
// directed plus randomized copies, checked against a sequential reference copy.
module tb_mem_copy_engine;

   logic clk;
   logic rst_n;

   mem_copy_if #(.BUS_WIDTH(32), .LEN_WIDTH(16)) bus ();

   mem_copy_engine #(.BUS_WIDTH(32), .LEN_WIDTH(16), .ADDR_INC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem     [0:1023];
   logic [31:0] exp_mem [0:1023];
   logic [31:0] wr_a[$];
   logic [31:0] wr_d[$];
   logic [31:0] rd_a[$];

   always_comb bus.RD = mem[bus.A[11:2]];

   always @(posedge clk) begin
      if (bus.WE) begin
         mem[bus.A[11:2]] = bus.WD;
         wr_a.push_back(bus.A);
         wr_d.push_back(bus.WD);
      end else if (bus.busy && !bus.done) begin
         rd_a.push_back(bus.A);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int busy_n, done_n, done_at, we_n;
   bit to;

   // Launches one copy and watches it at every falling edge until busy drops.
   // If pulse_at is nonzero, a foreign start is pulsed at that busy cycle.
   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           input int pulse_at);
      @(negedge clk);
      wr_a.delete(); wr_d.delete(); rd_a.delete();
      bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.len = l;
      @(negedge clk);
      bus.start = 1'b0;
      busy_n = 0; done_n = 0; done_at = 0; we_n = 0; to = 1'b1;
      for (int cyc = 1; cyc < 200; cyc++) begin
         if (pulse_at != 0 && cyc == pulse_at) begin
            bus.start = 1'b1; bus.src_addr = 32'h300; bus.dst_addr = 32'h400; bus.len = 16'd5;
         end else begin
            bus.start = 1'b0; bus.src_addr = s; bus.dst_addr = d; bus.len = l;
         end
         #1;
         if (bus.busy) busy_n++;
         if (bus.done) begin done_n++; done_at = cyc; end
         if (bus.WE) we_n++;
         if (!bus.busy) begin to = 1'b0; break; end
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
      #2;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.WE} !== 4'b0 || bus.A !== 32'h0 || bus.WD !== 32'h0
          || bus.words_done !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b WE=%b A=%h WD=%h wd=%0d, need all 0",
                  bus.busy, bus.done, bus.err, bus.WE, bus.A, bus.WD, bus.words_done);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_normal_copy();
      for (int i = 0; i < 4; i++) mem[i] = 32'd200 + 32'(i);
      run_copy(32'd0, 32'd64, 16'd4, 0);
      n_checks++;
      if (to || busy_n !== 9 || done_n !== 1 || done_at !== 9) begin
         n_fail++;
         $display("FAIL normal_timing: busy=%0d done_n=%0d done_at=%0d to=%b, need 9/1/9/0",
                  busy_n, done_n, done_at, to);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (mem[16 + i] !== 32'd200 + 32'(i)) begin
            n_fail++;
            $display("FAIL normal_data[%0d]: got %0d need %0d", i, mem[16 + i], 200 + i);
         end
      end
      n_checks++;
      if (bus.words_done !== 16'd4 || we_n !== 4 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL normal_status: words_done=%0d we=%0d err=%b, need 4/4/0",
                  bus.words_done, we_n, bus.err);
      end
   endtask

   task automatic test_zero_len();
      run_copy(32'h40, 32'h80, 16'd0, 0);
      n_checks++;
      if (to || busy_n !== 1 || done_n !== 1 || done_at !== 1 || we_n !== 0 || bus.err !== 1'b0
          || bus.words_done !== 16'd0) begin
         n_fail++;
         $display("FAIL zero_len: busy=%0d done_n=%0d at=%0d we=%0d err=%b wd=%0d, need 1/1/1/0/0/0",
                  busy_n, done_n, done_at, we_n, bus.err, bus.words_done);
      end
   endtask

   task automatic test_misaligned();
      run_copy(32'd2, 32'd64, 16'd3, 0);
      n_checks++;
      if (to || busy_n !== 1 || done_at !== 1 || we_n !== 0 || wr_a.size() !== 0
          || bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL misaligned: busy=%0d at=%0d we=%0d writes=%0d err=%b, need 1/1/0/0/1",
                  busy_n, done_at, we_n, wr_a.size(), bus.err);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: err=%b need 1", bus.err);
      end
      mem[0] = 32'h1234_5678;
      run_copy(32'd0, 32'd128, 16'd1, 0);
      n_checks++;
      if (bus.err !== 1'b0 || mem[32] !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL err_clear: err=%b mem=%h, need 0/12345678", bus.err, mem[32]);
      end
   endtask

   task automatic test_wrap();
      mem[1023] = 32'hAAAA_0001;
      mem[0]    = 32'hAAAA_0002;
      run_copy(32'hFFFF_FFFC, 32'd16, 16'd2, 0);
      n_checks++;
      if (rd_a.size() !== 2 || rd_a[0] !== 32'hFFFF_FFFC || rd_a[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_reads: n=%0d first=%h, need 2 reads FFFFFFFC,0", rd_a.size(),
                  (rd_a.size() > 0) ? rd_a[0] : 32'hx);
      end
      n_checks++;
      if (wr_a.size() !== 2 || wr_a[0] !== 32'd16 || wr_a[1] !== 32'd20
          || wr_d[0] !== 32'hAAAA_0001 || wr_d[1] !== 32'hAAAA_0002) begin
         n_fail++;
         $display("FAIL wrap_writes: n=%0d, need 16<-AAAA0001, 20<-AAAA0002", wr_a.size());
      end
      n_checks++;
      if (to || busy_n !== 5 || bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_status: busy=%0d err=%b, need 5/0", busy_n, bus.err);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         mem[i]      = 32'd500 + 32'(i);
         mem[16 + i] = 32'hDEAD_0000 + 32'(i);
      end
      @(negedge clk);
      wr_a.delete(); wr_d.delete(); rd_a.delete();
      bus.start = 1'b1; bus.src_addr = 32'd0; bus.dst_addr = 32'd64; bus.len = 16'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      // Busy cycle 4: the second WRITE.
      n_checks++;
      if (bus.WE !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: WE=%b need 1 in second write", bus.WE);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.err, bus.WE} !== 4'b0 || bus.A !== 32'h0 || bus.WD !== 32'h0
          || bus.words_done !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b WE=%b A=%h WD=%h wd=%0d",
                  bus.busy, bus.done, bus.err, bus.WE, bus.A, bus.WD, bus.words_done);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (wr_a.size() !== 1 || mem[16] !== 32'd500 || mem[17] !== 32'hDEAD_0001) begin
         n_fail++;
         $display("FAIL reset_mid_writes: writes=%0d mem16=%h mem17=%h, need 1/1f4/dead0001",
                  wr_a.size(), mem[16], mem[17]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_copy(32'd0, 32'd64, 16'd4, 0);
      n_checks++;
      if (to || busy_n !== 9 || bus.words_done !== 16'd4 || mem[16] !== 32'd500
          || mem[17] !== 32'd501 || mem[18] !== 32'd502 || mem[19] !== 32'd503) begin
         n_fail++;
         $display("FAIL reset_mid_recopy: busy=%0d wd=%0d mem16..19=%0d %0d %0d %0d",
                  busy_n, bus.words_done, mem[16], mem[17], mem[18], mem[19]);
      end
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < 3; i++) mem[64 + i] = 32'hC0DE_0000 + 32'(i);
      run_copy(32'h100, 32'h200, 16'd3, 2);
      n_checks++;
      if (to || busy_n !== 7 || done_n !== 1 || bus.words_done !== 16'd3) begin
         n_fail++;
         $display("FAIL busy_start_timing: busy=%0d done_n=%0d wd=%0d, need 7/1/3",
                  busy_n, done_n, bus.words_done);
      end
      n_checks++;
      if (wr_a.size() !== 3 || wr_a[0] !== 32'h200 || wr_a[1] !== 32'h204 || wr_a[2] !== 32'h208
          || rd_a.size() !== 3 || rd_a[0] !== 32'h100 || rd_a[2] !== 32'h108) begin
         n_fail++;
         $display("FAIL busy_start_addrs: writes=%0d reads=%0d, need 200..208 / 100..108",
                  wr_a.size(), rd_a.size());
      end
      n_checks++;
      if (mem[128] !== 32'hC0DE_0000 || mem[129] !== 32'hC0DE_0001 || mem[130] !== 32'hC0DE_0002)
      begin
         n_fail++;
         $display("FAIL busy_start_data: %h %h %h", mem[128], mem[129], mem[130]);
      end
   endtask

   task automatic test_random();
      logic [31:0] s, d;
      logic [15:0] l;
      bit          misal, exp_err;
      int          n, first_bad;
      for (int i = 0; i < 1023; i++) mem[i] = $urandom;
      for (int it = 0; it < 12; it++) begin
         s     = 32'($urandom_range(0, 200)) << 2;
         d     = 32'($urandom_range(0, 200)) << 2;
         l     = 16'($urandom_range(0, 8));
         misal = ($urandom_range(0, 4) == 0);
         if (misal) begin
            if ($urandom_range(0, 1) == 0) s = s + 32'($urandom_range(1, 3));
            else d = d + 32'($urandom_range(1, 3));
         end
         // Reference: an ascending word copy over a snapshot of memory.
         exp_mem = mem;
         exp_err = misal && (l != 0);
         n = (exp_err || l == 0) ? 0 : int'(l);
         for (int k = 0; k < n; k++) exp_mem[(d >> 2) + 32'(k)] = exp_mem[(s >> 2) + 32'(k)];
         run_copy(s, d, l, 0);
         n_checks++;
         if (to || busy_n !== 2 * n + 1 || done_n !== 1 || done_at !== 2 * n + 1) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: busy=%0d done_n=%0d at=%0d, need %0d/1/%0d",
                     it, busy_n, done_n, done_at, 2 * n + 1, 2 * n + 1);
         end
         n_checks++;
         if (bus.err !== exp_err || bus.words_done !== 16'(n) || we_n !== n) begin
            n_fail++;
            $display("FAIL rand_status[%0d]: err=%b wd=%0d we=%0d, need %b/%0d/%0d",
                     it, bus.err, bus.words_done, we_n, exp_err, n, n);
         end
         first_bad = -1;
         for (int k = 0; k < 1024; k++)
            if (first_bad < 0 && mem[k] !== exp_mem[k]) first_bad = k;
         n_checks++;
         if (first_bad >= 0) begin
            n_fail++;
            $display("FAIL rand_mem[%0d]: word %0d got %h need %h", it, first_bad,
                     mem[first_bad], exp_mem[first_bad]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      test_reset();
      test_normal_copy();
      test_zero_len();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
